// File: rtl/bird_motion_ctrl.sv
// Bird vertical-motion controller: integrates gravity and flap impulses once per
// frame, clamps the bird to the play field and handshakes each new row with the draw stage.
module bird_motion_ctrl #(
  parameter int Y_W     = 7,
  parameter int Y_START = 60,
  parameter int Y_MAX   = 119,
  parameter int FLAP_V  = 6,
  parameter int GRAV    = 1,
  parameter int V_MAX   = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go,
  input  logic           flap,
  input  logic           frame_tick,
  input  logic           collision,
  input  logic           draw_ack,
  output logic [Y_W-1:0] bird_y,
  output logic [4:0]     velocity,
  output logic [3:0]     state,
  output logic           draw_req,
  output logic           dead
);

  typedef enum logic [3:0] {
    IDLE       = 4'b0000,
    WAIT_FRAME = 4'b0001,
    UPDATE     = 4'b0010,
    DRAW       = 4'b0011,
    DEAD_ST    = 4'b1001
  } state_t;

  localparam int YS_W = Y_W + 2;
  localparam logic signed [4:0]      FLAP_NEG = 5'(-FLAP_V);
  localparam logic signed [5:0]      V_MAX_S  = 6'(V_MAX);
  localparam logic signed [5:0]      GRAV_S   = 6'(GRAV);
  localparam logic signed [YS_W-1:0] Y_MAX_S  = YS_W'(Y_MAX);

  state_t cur;
  logic go_prev, flap_prev, flap_pending, coll_latch;
  logic go_edge, flap_edge;
  logic signed [5:0]      v_inc;
  logic signed [4:0]      v_new;
  logic signed [YS_W-1:0] y_sum;
  logic ceil_hit, ground_hit;
  logic [Y_W-1:0] y_clamped;

  assign state     = cur;
  assign go_edge   = go & ~go_prev;
  assign flap_edge = flap & ~flap_prev;

  // Next-frame physics: y_sum is signed and two bits wider so both clamps are visible.
  always_comb begin
    v_inc      = $signed({velocity[4], velocity}) + GRAV_S;
    v_new      = flap_pending ? FLAP_NEG :
                 ((v_inc > V_MAX_S) ? V_MAX_S[4:0] : v_inc[4:0]);
    y_sum      = $signed({2'b00, bird_y}) + $signed({{(YS_W-5){v_new[4]}}, v_new});
    ceil_hit   = y_sum[YS_W-1];
    ground_hit = !ceil_hit && (y_sum >= Y_MAX_S);
    y_clamped  = ceil_hit ? '0 : (ground_hit ? Y_W'(Y_MAX) : y_sum[Y_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur          <= IDLE;
      bird_y       <= Y_W'(Y_START);
      velocity     <= '0;
      draw_req     <= 1'b0;
      dead         <= 1'b0;
      flap_pending <= 1'b0;
      coll_latch   <= 1'b0;
      go_prev      <= 1'b0;
      flap_prev    <= 1'b0;
    end else begin
      go_prev   <= go;
      flap_prev <= flap;
      case (cur)
        IDLE: if (go_edge) cur <= WAIT_FRAME;
        WAIT_FRAME: begin
          if (flap_edge) flap_pending <= 1'b1;
          if (collision) coll_latch <= 1'b1;
          if (frame_tick) cur <= UPDATE;
        end
        UPDATE: begin
          bird_y       <= y_clamped;
          velocity     <= ceil_hit ? 5'd0 : v_new;
          dead         <= dead | ground_hit | coll_latch | collision;
          flap_pending <= 1'b0;
          coll_latch   <= 1'b0;
          draw_req     <= 1'b1;
          cur          <= DRAW;
        end
        DRAW: begin
          // Ticks arriving here are dropped; flaps and hits carry into the next frame.
          if (flap_edge) flap_pending <= 1'b1;
          if (collision) coll_latch <= 1'b1;
          if (draw_ack) begin
            draw_req <= 1'b0;
            if (dead) begin
              velocity <= '0;
              cur      <= DEAD_ST;
            end else begin
              cur <= WAIT_FRAME;
            end
          end
        end
        DEAD_ST: if (go_edge) begin
          bird_y       <= Y_W'(Y_START);
          velocity     <= '0;
          dead         <= 1'b0;
          flap_pending <= 1'b0;
          coll_latch   <= 1'b0;
          cur          <= IDLE;
        end
        default: cur <= IDLE;
      endcase
    end
  end

endmodule
